// File: rtl/mycpu_mem_wb.sv
// mycpu_mem_wb: MEM + WB stages of the 5-stage MIPS pipe with SRAM lane alignment and bypass tags
module mycpu_mem_wb #(
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  input  logic [31:0] ex_pc,
  input  logic [31:0] ex_result,
  input  logic [31:0] ex_store_data,
  input  logic [4:0]  ex_target_reg,
  input  logic        ex_wen,
  input  logic [5:0]  ex_c8,
  output logic        data_sram_en,
  output logic [3:0]  data_sram_wen,
  output logic [31:0] data_sram_addr,
  output logic [31:0] data_sram_wdata,
  input  logic [31:0] data_sram_rdata,
  output logic        rf_wen,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic [5:0]  target_minus2,
  output logic [5:0]  target_minus3,
  output logic [31:0] mem2wb_cont,
  output logic [31:0] wb_cont,
  output logic        addr_err,
  output logic [31:0] debug_wb_pc,
  output logic [3:0]  debug_wb_rf_wen
);
  logic        ld, st, mis;
  logic [2:0]  sz;
  logic [1:0]  a;
  logic [4:0]  sh, shl;
  assign ld = ex_c8[5];
  assign st = ex_c8[4];
  assign sz = ex_c8[3:1];
  assign a = ex_result[1:0];
  assign sh = {a, 3'b000};
  assign shl = {~a, 3'b000};
  assign mis = (ld | st) & ((sz == 3'b001 & a[0]) | (sz == 3'b010 & a != 2'b00));
  assign data_sram_en = ex_valid & (ld | st) & ~mis & ~rst;
  assign data_sram_addr = ex_result;
  assign data_sram_wen = ~(data_sram_en & st) ? 4'b0000 :
                         sz == 3'b000 ? 4'b0001 << a :
                         sz == 3'b001 ? (a[1] ? 4'b1100 : 4'b0011) :
                         sz == 3'b011 ? 4'b1111 >> ~a :
                         sz == 3'b100 ? 4'b1111 << a : 4'b1111;
  assign data_sram_wdata = sz == 3'b000 ? {4{ex_store_data[7:0]}} :
                           sz == 3'b001 ? {2{ex_store_data[15:0]}} :
                           sz == 3'b011 ? ex_store_data >> shl :
                           sz == 3'b100 ? ex_store_data << sh : ex_store_data;
  logic        m_valid, m_wen, m_ld, m_sign, m_mis;
  logic [2:0]  m_sz;
  logic [4:0]  m_reg;
  logic [31:0] m_pc, m_result, m_rt;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_valid <= 1'b0;
      m_wen <= 1'b0;
      m_ld <= 1'b0;
      m_sign <= 1'b0;
      m_mis <= 1'b0;
      m_sz <= 3'b000;
      m_reg <= 5'd0;
      m_pc <= 32'h0;
      m_result <= 32'h0;
      m_rt <= 32'h0;
    end else begin
      m_valid <= ex_valid;
      m_wen <= ex_wen;
      m_ld <= ld;
      m_sign <= ex_c8[0];
      m_mis <= mis;
      m_sz <= sz;
      m_reg <= ex_target_reg;
      m_pc <= ex_pc;
      m_result <= ex_result;
      m_rt <= ex_store_data;
    end
  end
  logic        m_wr;
  logic [1:0]  ma;
  logic [4:0]  msh, mshl;
  logic [7:0]  byte_l;
  logic [15:0] half_l;
  logic [31:0] ld_val, m_val;
  assign m_wr = m_valid & m_wen & ~m_mis & (m_reg != 5'd0);
  assign target_minus2 = m_wr ? {m_ld, m_reg} : 6'b0;
  assign mem2wb_cont = (m_wr & ~m_ld) ? m_result : 32'h0;
  assign ma = m_result[1:0];
  assign msh = {ma, 3'b000};
  assign mshl = {~ma, 3'b000};
  assign byte_l = 8'(data_sram_rdata >> msh);
  assign half_l = ma[1] ? data_sram_rdata[31:16] : data_sram_rdata[15:0];
  // LWL keeps the low rt bytes below the loaded ones; LWR keeps the high rt bytes above them
  assign ld_val = m_sz == 3'b000 ? {{24{m_sign & byte_l[7]}}, byte_l} :
                  m_sz == 3'b001 ? {{16{m_sign & half_l[15]}}, half_l} :
                  m_sz == 3'b011 ? (data_sram_rdata << mshl) | (m_rt & (32'h00FF_FFFF >> msh)) :
                  m_sz == 3'b100 ? (data_sram_rdata >> msh) | (m_rt & ~(32'hFFFF_FFFF >> msh)) :
                  data_sram_rdata;
  assign m_val = m_ld ? ld_val : m_result;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rf_wen <= 1'b0;
      rf_waddr <= 5'd0;
      rf_wdata <= 32'h0;
      addr_err <= 1'b0;
      debug_wb_pc <= RESET_PC;
    end else begin
      rf_wen <= m_wr;
      rf_waddr <= m_wr ? m_reg : 5'd0;
      rf_wdata <= m_wr ? m_val : 32'h0;
      addr_err <= m_valid & m_mis;
      debug_wb_pc <= m_valid ? m_pc : debug_wb_pc;
    end
  end
  assign target_minus3 = {1'b0, rf_waddr};
  assign wb_cont = rf_wdata;
  assign debug_wb_rf_wen = {4{rf_wen}};
endmodule
